bit_serializer: RTL and testbench

//   Parallel-to-serial stage feeding the serial pattern detector's 1-bit input.

---
 rtl/seq_det_pkg.sv | 13 +
 rtl/bit_serializer.sv | 117 +++++++++++
 tb/tb_bit_serializer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared types for the serial pattern-detector slice.
// Serializer state encoding and bit-order selectors.
package seq_det_pkg;

    typedef enum logic {
        SER_IDLE,
        SER_SHIFT
    } ser_state_t;

    localparam bit SER_MSB_FIRST = 1'b1;
    localparam bit SER_LSB_FIRST = 1'b0;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage with a one-word holding register.
// Shifts WIDTH-bit words out one bit per bit_tick, gapless back-to-back.
module bit_serializer
    import seq_det_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = SER_MSB_FIRST,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_tick,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    ser_state_t       state, state_n;
    logic [WIDTH-1:0] hold, hold_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic             hold_full, hold_full_n;
    logic [CW-1:0]    bitcnt, bitcnt_n;
    logic             ser_out_n;
    logic             ser_valid_n;
    logic             word_done_n;
    logic             load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SER_IDLE;
            hold      <= '0;
            shreg     <= '0;
            hold_full <= 1'b0;
            bitcnt    <= '0;
            ser_out   <= IDLE_BIT;
            ser_valid <= 1'b0;
            word_done <= 1'b0;
        end else begin
            state     <= state_n;
            hold      <= hold_n;
            shreg     <= shreg_n;
            hold_full <= hold_full_n;
            bitcnt    <= bitcnt_n;
            ser_out   <= ser_out_n;
            ser_valid <= ser_valid_n;
            word_done <= word_done_n;
        end
    end

    always_comb begin
        state_n     = state;
        hold_n      = hold;
        shreg_n     = shreg;
        hold_full_n = hold_full;
        bitcnt_n    = bitcnt;
        ser_out_n   = ser_out;
        ser_valid_n = ser_valid;
        word_done_n = 1'b0;
        load        = 1'b0;

        if (bit_tick) begin
            unique case (state)
                SER_IDLE: begin
                    load = hold_full;
                end
                SER_SHIFT: begin
                    if (bitcnt != '0) begin
                        bitcnt_n = bitcnt - 1'b1;
                        if (MSB_FIRST) begin
                            shreg_n   = {shreg[WIDTH-2:0], 1'b0};
                            ser_out_n = shreg[WIDTH-2];
                        end else begin
                            shreg_n   = {1'b0, shreg[WIDTH-1:1]};
                            ser_out_n = shreg[1];
                        end
                    end else begin
                        word_done_n = 1'b1;
                        if (hold_full) begin
                            load = 1'b1;
                        end else begin
                            state_n     = SER_IDLE;
                            ser_out_n   = IDLE_BIT;
                            ser_valid_n = 1'b0;
                        end
                    end
                end
                default: state_n = SER_IDLE;
            endcase
        end

        // Load and accept are mutually exclusive: accept needs hold empty.
        if (load) begin
            state_n     = SER_SHIFT;
            shreg_n     = hold;
            hold_full_n = 1'b0;
            bitcnt_n    = LAST;
            ser_valid_n = 1'b1;
            ser_out_n   = MSB_FIRST ? hold[WIDTH-1] : hold[0];
        end

        if (s_valid && s_ready) begin
            hold_n      = s_data;
            hold_full_n = 1'b1;
        end
    end

    assign s_ready = !hold_full && !rst;
    assign busy    = (state == SER_SHIFT) || hold_full;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: MSB- and LSB-first instances,
// gapless streaming, slow ticks, mid-word reset, 1001 detection.
module tb_bit_serializer;
    import seq_det_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_tick;
    logic       s_valid_m, s_valid_l;
    logic [7:0] s_data;
    logic       s_ready_m, ser_out_m, ser_valid_m, word_done_m, busy_m;
    logic       s_ready_l, ser_out_l, ser_valid_l, word_done_l, busy_l;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  w;
    logic [15:0] st;
    logic [3:0]  win;
    int          nb;
    logic        det;

    always #5 clk = ~clk;

    bit_serializer #(
        .WIDTH(8), .MSB_FIRST(SER_MSB_FIRST), .IDLE_BIT(1'b0)
    ) dut_m (
        .clk(clk), .rst(rst), .bit_tick(bit_tick),
        .s_valid(s_valid_m), .s_ready(s_ready_m), .s_data(s_data),
        .ser_out(ser_out_m), .ser_valid(ser_valid_m),
        .word_done(word_done_m), .busy(busy_m)
    );

    bit_serializer #(
        .WIDTH(8), .MSB_FIRST(SER_LSB_FIRST), .IDLE_BIT(1'b0)
    ) dut_l (
        .clk(clk), .rst(rst), .bit_tick(bit_tick),
        .s_valid(s_valid_l), .s_ready(s_ready_l), .s_data(s_data),
        .ser_out(ser_out_l), .ser_valid(ser_valid_l),
        .word_done(word_done_l), .busy(busy_l)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        bit_tick  = 1'b0;
        s_valid_m = 1'b0;
        s_valid_l = 1'b0;
        s_data    = '0;
        step(); step(); step();

        // reset state
        chk("rst_ser_out", ser_out_m, 1'b0);
        chk("rst_ser_valid", ser_valid_m, 1'b0);
        chk("rst_s_ready", s_ready_m, 1'b0);
        chk("rst_busy", busy_m, 1'b0);
        chk("rst_word_done", word_done_m, 1'b0);
        rst = 1'b0;
        #1;
        chk("rel_s_ready", s_ready_m, 1'b1);
        chk("rel_s_ready_l", s_ready_l, 1'b1);

        // 1: MSB first, 8'h99
        bit_tick  = 1'b1;
        w         = 8'h99;
        s_data    = w;
        s_valid_m = 1'b1;
        step();
        chk("t1_acc_ready", s_ready_m, 1'b0);
        chk("t1_acc_busy", busy_m, 1'b1);
        chk("t1_acc_valid", ser_valid_m, 1'b0);
        s_valid_m = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t1_out", ser_out_m, w[7-i]);
            chk("t1_valid", ser_valid_m, 1'b1);
            chk("t1_done", word_done_m, 1'b0);
        end
        step();
        chk("t1_end_done", word_done_m, 1'b1);
        chk("t1_end_valid", ser_valid_m, 1'b0);
        chk("t1_end_out", ser_out_m, 1'b0);
        chk("t1_end_busy", busy_m, 1'b0);
        step();
        chk("t1_done_pulse", word_done_m, 1'b0);

        // 2: LSB first, 8'h01
        w         = 8'h01;
        s_data    = w;
        s_valid_l = 1'b1;
        step();
        s_valid_l = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t2_out", ser_out_l, w[i]);
            chk("t2_valid", ser_valid_l, 1'b1);
        end
        step();
        chk("t2_end_done", word_done_l, 1'b1);
        chk("t2_end_valid", ser_valid_l, 1'b0);
        step();

        // 3: back-to-back A5, 3C
        st        = 16'hA53C;
        s_data    = 8'hA5;
        s_valid_m = 1'b1;
        step();
        chk("t3_acc_ready", s_ready_m, 1'b0);
        s_data = 8'h3C;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("t3_out", ser_out_m, st[16-i]);
            chk("t3_valid", ser_valid_m, 1'b1);
            chk("t3_done", word_done_m, i == 9);
            chk("t3_ready", s_ready_m, (i == 1) || (i >= 9));
            if (i == 2) s_valid_m = 1'b0;
        end
        step();
        chk("t3_end_done", word_done_m, 1'b1);
        chk("t3_end_valid", ser_valid_m, 1'b0);
        step();

        // 4: tick every 4th clk, 8'hF0
        w         = 8'hF0;
        s_data    = w;
        s_valid_m = 1'b1;
        bit_tick  = 1'b0;
        step();
        chk("t4_acc_valid", ser_valid_m, 1'b0);
        s_valid_m = 1'b0;
        for (int j = 1; j <= 32; j++) begin
            bit_tick = ((j - 1) % 4) == 0;
            step();
            chk("t4_out", ser_out_m, w[7-(j-1)/4]);
            chk("t4_valid", ser_valid_m, 1'b1);
            chk("t4_done", word_done_m, 1'b0);
        end
        bit_tick = 1'b1;
        step();
        chk("t4_end_done", word_done_m, 1'b1);
        chk("t4_end_valid", ser_valid_m, 1'b0);
        step();

        // 5: reset during bit 3 of FF with 81 held
        s_data    = 8'hFF;
        s_valid_m = 1'b1;
        step();
        s_data = 8'h81;
        step();
        chk("t5_bit1", ser_out_m, 1'b1);
        step();
        chk("t5_held_ready", s_ready_m, 1'b0);
        s_valid_m = 1'b0;
        step();
        chk("t5_bit3", ser_out_m, 1'b1);
        rst = 1'b1;
        #1;
        chk("t5_rst_out", ser_out_m, 1'b0);
        chk("t5_rst_valid", ser_valid_m, 1'b0);
        chk("t5_rst_ready", s_ready_m, 1'b0);
        step();
        chk("t5_rst_ready2", s_ready_m, 1'b0);
        rst = 1'b0;
        #1;
        chk("t5_rel_ready", s_ready_m, 1'b1);
        chk("t5_rel_busy", busy_m, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t5_no_emit", ser_valid_m, 1'b0);
            chk("t5_idle_out", ser_out_m, 1'b0);
        end

        // 6: 8'h99 into a 1001 detector
        win       = '0;
        nb        = 0;
        s_data    = 8'h99;
        s_valid_m = 1'b1;
        step();
        s_valid_m = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (ser_valid_m) begin
                win = {win[2:0], ser_out_m};
                nb++;
            end
            det = ser_valid_m && (nb >= 4) && (win == 4'b1001);
            chk("t6_det", det, (i == 4) || (i == 8));
        end
        step();
        chk("t6_end_done", word_done_m, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
